// File: rtl/chip8_timers.sv
// CHIP-8 delay and sound timers driven by a synchronized 60 Hz tick.
// Optional build macro CHIP8_ST_MIN2_EN gates beep on ST >= 2 instead of ST != 0.
module chip8_timers #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned WIDTH       = 8
) (
   input  logic             clk_in,
   input  logic             res_n,
   input  logic             tick_in,
   input  logic             hold_in,
   input  logic             wr_dt,
   input  logic             wr_st,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] dt,
   output logic [WIDTH-1:0] st,
   output logic             beep,
   output logic             tick_pulse
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;
   logic                   dec;
   logic [WIDTH-1:0]       dt_d;
   logic [WIDTH-1:0]       st_d;
   logic                   beep_d;

   always_ff @(posedge clk_in or negedge res_n) begin
      if (!res_n) begin
         sync       <= '0;
         prev       <= 1'b0;
         tick_pulse <= 1'b0;
      end else begin
         sync       <= {sync[SYNC_STAGES-2:0], tick_in};
         prev       <= sync[SYNC_STAGES-1];
         tick_pulse <= sync[SYNC_STAGES-1] & ~prev;
      end
   end

   // Loads override a coincident decrement; zero saturates.
   always_comb begin
      dec  = tick_pulse & ~hold_in;
      dt_d = dt;
      st_d = st;
      if (dec && (dt != '0)) dt_d = dt - WIDTH'(1);
      if (dec && (st != '0)) st_d = st - WIDTH'(1);
      if (wr_dt) dt_d = wr_data;
      if (wr_st) st_d = wr_data;
`ifdef CHIP8_ST_MIN2_EN
      beep_d = (st_d >= WIDTH'(2));
`else
      beep_d = (st_d != '0);
`endif
   end

   always_ff @(posedge clk_in or negedge res_n) begin
      if (!res_n) begin
         dt   <= '0;
         st   <= '0;
         beep <= 1'b0;
      end else begin
         dt   <= dt_d;
         st   <= st_d;
         beep <= beep_d;
      end
   end

endmodule

// File: tb/tb_chip8_timers.sv
// Randomized scoreboard bench for chip8_timers with a value-level timer model.
module tb_chip8_timers;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned WIDTH       = 8;

   logic             clk_in  = 1'b0;
   logic             res_n   = 1'b1;
   logic             tick_in = 1'b0;
   logic             hold_in = 1'b0;
   logic             wr_dt   = 1'b0;
   logic             wr_st   = 1'b0;
   logic [WIDTH-1:0] wr_data = '0;
   logic [WIDTH-1:0] dt;
   logic [WIDTH-1:0] st;
   logic             beep;
   logic             tick_pulse;

   chip8_timers #(
      .SYNC_STAGES(SYNC_STAGES),
      .WIDTH      (WIDTH)
   ) dut (
      .clk_in    (clk_in),
      .res_n     (res_n),
      .tick_in   (tick_in),
      .hold_in   (hold_in),
      .wr_dt     (wr_dt),
      .wr_st     (wr_st),
      .wr_data   (wr_data),
      .dt        (dt),
      .st        (st),
      .beep      (beep),
      .tick_pulse(tick_pulse)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   typedef struct {
      int pulse_cyc;
      int pre_dt;
      int pre_st;
      int post_dt;
      int post_st;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   mdt = 0;
   int   mst = 0;
   int   max_val = (1 << WIDTH) - 1;

   function automatic int beep_of(input int s);
`ifdef CHIP8_ST_MIN2_EN
      return (s >= 2) ? 1 : 0;
`else
      return (s != 0) ? 1 : 0;
`endif
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: each tick_pulse pops one expectation; values checked before and after decrement.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_in);
         if (res_n && tick_pulse) begin
            if (sb.size() == 0) begin
               chk("unexpected_pulse", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("pulse_cycle", cyc, e.pulse_cyc);
               chk("pre_dt", int'(dt), e.pre_dt);
               chk("pre_st", int'(st), e.pre_st);
               chk("pre_beep", int'(beep), beep_of(e.pre_st));
               @(negedge clk_in);
               chk("pulse_width", int'(tick_pulse), 0);
               chk("post_dt", int'(dt), e.post_dt);
               chk("post_st", int'(st), e.post_st);
               chk("post_beep", int'(beep), beep_of(e.post_st));
            end
         end
      end
   end

   task automatic do_write(input bit wd, input bit ws, input int val);
      @(posedge clk_in);
      #1;
      wr_dt   = wd;
      wr_st   = ws;
      wr_data = WIDTH'(val);
      @(posedge clk_in);
      #1;
      wr_dt = 1'b0;
      wr_st = 1'b0;
      if (wd) mdt = val;
      if (ws) mst = val;
      chk("write_dt", int'(dt), mdt);
      chk("write_st", int'(st), mst);
      chk("write_beep", int'(beep), beep_of(mst));
   endtask

   // One tick_in period (4 high, 4 low); optional load on the decrement edge.
   task automatic do_tick(input bit hold, input bit wd, input bit ws, input int val);
      int   c;
      exp_t e;
      @(posedge clk_in);
      #1;
      tick_in = 1'b1;
      hold_in = hold;
      c = cyc;
      e.pulse_cyc = c + 1 + SYNC_STAGES;
      e.pre_dt = mdt;
      e.pre_st = mst;
      if (!hold) begin
         if (mdt > 0) mdt = mdt - 1;
         if (mst > 0) mst = mst - 1;
      end
      if (wd) mdt = val;
      if (ws) mst = val;
      e.post_dt = mdt;
      e.post_st = mst;
      sb.push_back(e);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk_in);
         #1;
         if (k == SYNC_STAGES + 1 && (wd || ws)) begin
            wr_dt   = wd;
            wr_st   = ws;
            wr_data = WIDTH'(val);
         end
         if (k == SYNC_STAGES + 2) begin
            wr_dt = 1'b0;
            wr_st = 1'b0;
         end
         if (k == 4) tick_in = 1'b0;
      end
   endtask

   initial begin
      #1 res_n = 1'b0;
      #1;
      chk("reset_dt", int'(dt), 0);
      chk("reset_st", int'(st), 0);
      chk("reset_beep", int'(beep), 0);
      chk("reset_pulse", int'(tick_pulse), 0);
      @(negedge clk_in);
      res_n = 1'b1;

      // Countdown with saturation.
      do_write(1, 0, 3);
      for (int i = 0; i < 5; i++) do_tick(0, 0, 0, 0);

      // Load collides with decrement.
      do_write(0, 1, 4);
      do_tick(0, 1, 0, 'h10);

      // Held ticks are dropped but still pulse.
      do_write(1, 0, 5);
      do_tick(1, 0, 0, 0);
      do_tick(1, 0, 0, 0);
      do_tick(0, 0, 0, 0);

      // Beep threshold around 2, 1, 0.
      do_write(0, 1, 2);
      do_tick(0, 0, 0, 0);
      do_tick(0, 0, 0, 0);
      do_write(0, 1, 1);
      do_tick(0, 0, 0, 0);
      do_write(1, 1, max_val);
      do_tick(0, 0, 0, 0);

      for (int i = 0; i < 24; i++) begin
         int op;
         op = int'($urandom_range(0, 3));
         if (op == 0) begin
            do_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 6)));
         end else if (op == 1) begin
            do_tick(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, max_val)));
         end else begin
            do_tick(($urandom_range(0, 3) == 0), 0, 0, 0);
         end
      end

      // Asynchronous reset mid-count with a tick partway through the synchronizer.
      do_write(1, 1, 'h20);
      do_write(0, 1, 5);
      @(posedge clk_in);
      #1 tick_in = 1'b1;
      @(posedge clk_in);
      #2 res_n = 1'b0;
      #1;
      chk("async_dt", int'(dt), 0);
      chk("async_st", int'(st), 0);
      chk("async_beep", int'(beep), 0);
      tick_in = 1'b0;
      mdt = 0;
      mst = 0;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      res_n = 1'b1;
      repeat (6) @(posedge clk_in);
      do_write(1, 1, 2);
      do_tick(0, 0, 0, 0);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk_in);
      repeat (3) @(negedge clk_in);
      chk("scoreboard_drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
